// File: rtl/mvau_stream_ctrl_hs.sv
`default_nettype none
// ============================================================================
//  Module   : mvau_stream_ctrl_hs
//  Brief    : MVAU stream controller with ready/valid handshakes on input and
//             output, input-buffer reuse sequencing and accumulator latency.
//  Revision : 1.0
// ============================================================================
module mvau_stream_ctrl_hs #(
    parameter int SF      = 8,
    parameter int NF      = 4,
    parameter int SF_T    = (SF > 1) ? $clog2(SF) : 1,
    parameter int NF_T    = (NF > 1) ? $clog2(NF) : 1,
    parameter int ACC_LAT = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_v,
    output logic            in_rdy,
    input  logic            out_rdy,
    output logic            out_v,
    output logic            dp_en,
    output logic            do_mvau_stream,
    output logic            ib_wen,
    output logic            ib_ren,
    output logic            acc_clr,
    output logic            sf_last,
    output logic [SF_T-1:0] sf_cnt,
    output logic [NF_T-1:0] nf_cnt
);

    localparam logic [SF_T-1:0] c_SF_LAST = SF_T'(SF - 1);
    localparam logic [NF_T-1:0] c_NF_LAST = NF_T'(NF - 1);

    typedef enum logic [0:0] {
        ST_FILL  = 1'b0,
        ST_REUSE = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [SF_T-1:0]    r_sf_cnt;
    logic [NF_T-1:0]    r_nf_cnt;
    logic [ACC_LAT-1:0] r_lat_sr;
    logic               w_stall;
    logic               w_beat;
    logic               w_sf_last;
    logic               w_nf_last;

    assign w_sf_last = (r_sf_cnt == c_SF_LAST);
    assign w_nf_last = (r_nf_cnt == c_NF_LAST);
    assign out_v     = r_lat_sr[ACC_LAT-1];
    assign w_stall   = out_v & ~out_rdy;

    assign dp_en          = ~w_stall;
    assign do_mvau_stream = w_beat;
    assign acc_clr        = w_beat & (r_sf_cnt == '0);
    assign sf_last        = w_sf_last;
    assign sf_cnt         = r_sf_cnt;
    assign nf_cnt         = r_nf_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A beat never happens under stall, so every transition is implicitly frozen.
    // With NF=1 nf_last is always true, which keeps the FSM parked in FILL.
    always_comb begin
        w_state_nxt = r_state;
        in_rdy      = 1'b0;
        w_beat      = 1'b0;
        ib_wen      = 1'b0;
        ib_ren      = 1'b0;
        case (r_state)
            ST_FILL: begin
                in_rdy = rst_n & ~w_stall;
                w_beat = rst_n & ~w_stall & in_v;
                ib_wen = w_beat;
                if (w_beat && w_sf_last && !w_nf_last) begin
                    w_state_nxt = ST_REUSE;
                end
            end
            ST_REUSE: begin
                w_beat = ~w_stall;
                ib_ren = w_beat;
                if (w_beat && w_sf_last && w_nf_last) begin
                    w_state_nxt = ST_FILL;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sf_cnt <= '0;
            r_nf_cnt <= '0;
        end else if (w_beat) begin
            r_sf_cnt <= w_sf_last ? '0 : r_sf_cnt + SF_T'(1);
            if (w_sf_last) begin
                r_nf_cnt <= w_nf_last ? '0 : r_nf_cnt + NF_T'(1);
            end
        end
    end

    // Result-valid tracker: a token per finished SF sweep, frozen while stalled.
    generate
        if (ACC_LAT == 1) begin : g_lat_single
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_lat_sr <= '0;
                end else if (!w_stall) begin
                    r_lat_sr <= w_beat & w_sf_last;
                end
            end
        end else begin : g_lat_shift
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_lat_sr <= '0;
                end else if (!w_stall) begin
                    r_lat_sr <= {r_lat_sr[ACC_LAT-2:0], w_beat & w_sf_last};
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_mvau_stream_ctrl_hs.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mvau_stream_ctrl_hs
//  Brief    : Three controller configurations driven by shared random
//             handshake stimulus and checked against a sequence-level model.
//  Revision : 1.0
// ============================================================================
module tb_mvau_stream_ctrl_hs;

    logic clk = 1'b0;
    logic rst_n;
    logic in_v;
    logic out_rdy;

    always #5 clk = ~clk;

    logic [2:0] in_rdy_a, out_v_a, dp_en_a, do_a, wen_a, ren_a, clr_a, last_a;
    logic [2:0] sf0;
    logic [1:0] sf1;
    logic [0:0] sf2;
    logic [1:0] nf0;
    logic [0:0] nf1;
    logic [1:0] nf2;
    int         sf_a[3];
    int         nf_a[3];

    always_comb begin
        sf_a[0] = int'(sf0);
        sf_a[1] = int'(sf1);
        sf_a[2] = int'(sf2);
        nf_a[0] = int'(nf0);
        nf_a[1] = int'(nf1);
        nf_a[2] = int'(nf2);
    end

    mvau_stream_ctrl_hs #(.SF(8), .NF(4), .ACC_LAT(2)) u_c0 (
        .clk(clk), .rst_n(rst_n), .in_v(in_v), .in_rdy(in_rdy_a[0]),
        .out_rdy(out_rdy), .out_v(out_v_a[0]), .dp_en(dp_en_a[0]),
        .do_mvau_stream(do_a[0]), .ib_wen(wen_a[0]), .ib_ren(ren_a[0]),
        .acc_clr(clr_a[0]), .sf_last(last_a[0]), .sf_cnt(sf0), .nf_cnt(nf0)
    );

    mvau_stream_ctrl_hs #(.SF(4), .NF(1), .ACC_LAT(2)) u_c1 (
        .clk(clk), .rst_n(rst_n), .in_v(in_v), .in_rdy(in_rdy_a[1]),
        .out_rdy(out_rdy), .out_v(out_v_a[1]), .dp_en(dp_en_a[1]),
        .do_mvau_stream(do_a[1]), .ib_wen(wen_a[1]), .ib_ren(ren_a[1]),
        .acc_clr(clr_a[1]), .sf_last(last_a[1]), .sf_cnt(sf1), .nf_cnt(nf1)
    );

    mvau_stream_ctrl_hs #(.SF(1), .NF(3), .ACC_LAT(3)) u_c2 (
        .clk(clk), .rst_n(rst_n), .in_v(in_v), .in_rdy(in_rdy_a[2]),
        .out_rdy(out_rdy), .out_v(out_v_a[2]), .dp_en(dp_en_a[2]),
        .do_mvau_stream(do_a[2]), .ib_wen(wen_a[2]), .ib_ren(ren_a[2]),
        .acc_clr(clr_a[2]), .sf_last(last_a[2]), .sf_cnt(sf2), .nf_cnt(nf2)
    );

    function automatic int f_sf(input int k);
        case (k)
            0:       return 8;
            1:       return 4;
            default: return 1;
        endcase
    endfunction

    function automatic int f_nf(input int k);
        case (k)
            0:       return 4;
            1:       return 1;
            default: return 3;
        endcase
    endfunction

    function automatic int f_acc(input int k);
        return (k == 2) ? 3 : 2;
    endfunction

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int k, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s cfg=%0d t=%0t got=%0d want=%0d", nm, k, $time, act, exp);
        end
    endtask

    // Model: position in the SF*NF beat sequence of one input vector, plus the
    // ages of finished sweeps still travelling towards the output.
    int m_idx[3];
    int m_age[3][8];
    int m_n[3];

    initial begin
        int  sf, nf, acc, pos, vec;
        bit  fill, ov, stall, rdy, beat, last;
        for (int k = 0; k < 3; k++) begin
            m_idx[k] = 0;
            m_n[k]   = 0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (!rst_n) begin
                    m_idx[k] = 0;
                    m_n[k]   = 0;
                    chk("rst_out_v",  k, int'(out_v_a[k]),  0);
                    chk("rst_in_rdy", k, int'(in_rdy_a[k]), 0);
                    chk("rst_ib_wen", k, int'(wen_a[k]),    0);
                    chk("rst_ib_ren", k, int'(ren_a[k]),    0);
                    chk("rst_sf_cnt", k, sf_a[k],           0);
                    chk("rst_nf_cnt", k, nf_a[k],           0);
                end else begin
                    sf    = f_sf(k);
                    nf    = f_nf(k);
                    acc   = f_acc(k);
                    pos   = m_idx[k] % sf;
                    vec   = m_idx[k] / sf;
                    fill  = (vec == 0);
                    last  = (pos == sf - 1);
                    ov    = (m_n[k] > 0) && (m_age[k][0] == acc);
                    stall = ov && !out_rdy;
                    rdy   = fill && !stall;
                    beat  = fill ? (in_v && rdy) : !stall;
                    chk("out_v",   k, int'(out_v_a[k]),  int'(ov));
                    chk("in_rdy",  k, int'(in_rdy_a[k]), int'(rdy));
                    chk("dp_en",   k, int'(dp_en_a[k]),  int'(!stall));
                    chk("do_beat", k, int'(do_a[k]),     int'(beat));
                    chk("ib_wen",  k, int'(wen_a[k]),    int'(beat && fill));
                    chk("ib_ren",  k, int'(ren_a[k]),    int'(beat && !fill));
                    chk("acc_clr", k, int'(clr_a[k]),    int'(beat && pos == 0));
                    chk("sf_last", k, int'(last_a[k]),   int'(last));
                    chk("sf_cnt",  k, sf_a[k],           pos);
                    chk("nf_cnt",  k, nf_a[k],           vec);
                    if (!stall) begin
                        if (ov) begin
                            for (int j = 0; j < m_n[k] - 1; j++) m_age[k][j] = m_age[k][j+1];
                            m_n[k]--;
                        end
                        for (int j = 0; j < m_n[k]; j++) m_age[k][j]++;
                        if (beat && last && m_n[k] < 8) begin
                            m_age[k][m_n[k]] = 1;
                            m_n[k]++;
                        end
                    end
                    if (beat) m_idx[k] = (m_idx[k] + 1) % (sf * nf);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog t=%0t got=timeout want=finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ov_cnt[3];
        int wen_cnt[3];
        int ren_cnt[3];
        int clr2;
        int first_ov;
        int hold;
        bit found;
        for (int k = 0; k < 3; k++) begin
            ov_cnt[k]  = 0;
            wen_cnt[k] = 0;
            ren_cnt[k] = 0;
        end
        clr2     = 0;
        first_ov = -1;
        hold     = 0;
        found    = 1'b0;

        rst_n   = 1'b0;
        in_v    = 1'b0;
        out_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        in_v  = 1'b1;
        rst_n = 1'b1;

        // Continuous streaming with no backpressure; cycle 0 is the first beat.
        for (int c = 0; c < 34; c++) begin
            @(negedge clk);
            #1;
            for (int k = 0; k < 3; k++) begin
                if (out_v_a[k]) ov_cnt[k]++;
                if (c < 32 && wen_a[k]) wen_cnt[k]++;
                if (c < 32 && ren_a[k]) ren_cnt[k]++;
            end
            if (c < 32 && clr_a[2]) clr2++;
            if (out_v_a[0] && first_ov < 0) first_ov = c;
            if (c == 8) chk("reuse_in_rdy_low", 0, int'(in_rdy_a[0]), 0);
            if (c == 32) begin
                chk("vec2_accept", 0, int'(wen_a[0]), 1);
                chk("vec2_addr",   0, sf_a[0],        0);
            end
        end
        chk("first_out_cycle", 0, first_ov,   9);
        chk("out_pulses",      0, ov_cnt[0],  4);
        chk("out_pulses",      1, ov_cnt[1],  8);
        chk("out_pulses",      2, ov_cnt[2],  31);
        chk("wen_count",       0, wen_cnt[0], 8);
        chk("wen_count",       1, wen_cnt[1], 32);
        chk("wen_count",       2, wen_cnt[2], 11);
        chk("ren_count",       0, ren_cnt[0], 24);
        chk("ren_count",       1, ren_cnt[1], 0);
        chk("ren_count",       2, ren_cnt[2], 21);
        chk("clr_count",       2, clr2,       32);

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #2;
            if (hold > 0) begin
                out_rdy = 1'b0;
                hold--;
            end else if ($urandom_range(0, 39) == 0) begin
                out_rdy = 1'b0;
                hold    = 4;
            end else begin
                out_rdy = ($urandom_range(0, 3) != 0);
            end
            in_v = ($urandom_range(0, 3) != 0);
        end

        // Asynchronous reset in the middle of the third sweep of configuration 0.
        for (int c = 0; c < 300 && !found; c++) begin
            @(posedge clk);
            #2;
            in_v    = 1'b1;
            out_rdy = 1'b1;
            if (m_idx[0] == 2 * 8 + 5) found = 1'b1;
        end
        chk("reset_point_reached", 0, int'(found), 1);
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("async_out_v",   k, int'(out_v_a[k]),  0);
            chk("async_in_rdy",  k, int'(in_rdy_a[k]), 0);
            chk("async_ib_wen",  k, int'(wen_a[k]),    0);
            chk("async_ib_ren",  k, int'(ren_a[k]),    0);
            chk("async_acc_clr", k, int'(clr_a[k]),    0);
            chk("async_do",      k, int'(do_a[k]),     0);
            chk("async_sf_cnt",  k, sf_a[k],           0);
            chk("async_nf_cnt",  k, nf_a[k],           0);
        end
        repeat (2) @(posedge clk);
        #2;
        rst_n   = 1'b1;
        in_v    = 1'b1;
        out_rdy = 1'b1;
        @(negedge clk);
        #1;
        chk("post_rst_in_rdy", 0, int'(in_rdy_a[0]), 1);
        chk("post_rst_ib_wen", 0, int'(wen_a[0]),    1);
        chk("post_rst_addr",   0, sf_a[0],           0);
        chk("post_rst_clr",    0, int'(clr_a[0]),    1);

        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            #2;
            out_rdy = ($urandom_range(0, 2) != 0);
            in_v    = ($urandom_range(0, 2) != 0);
        end
        @(negedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mvau_stream_ctrl_hs.md
Name: mvau_stream_ctrl_hs

Overview:
- Next-generation control unit for the MVAU streaming block. Adds ready/valid backpressure on the input activation stream and the output stream, plus an accumulator-latency tracking pipeline.
- Drives the input-buffer write/read enables and address, the accumulator clear, and a global datapath enable.
- Supports any NF≥1 and SF≥1 through one code path, with no separate NF=1 special case.
- Sits between the input activation stream, the input buffer, the PE/SIMD datapath and the output stream.

Parameters:
- SF, 8, number of SIMD chunks per output vector (input buffer depth); ≥1
- NF, 4, number of PE chunks (output vectors) per input vector; ≥1
- SF_T, max(1,$clog2(SF)), sf_cnt width
- NF_T, max(1,$clog2(NF)), nf_cnt width
- ACC_LAT, 2, cycles from the last SF beat to the accumulator result being valid; ≥1

Ports:
- clk  in  1  main clock
- rst_n  in  1  asynchronous active-low reset
- in_v  in  1  input activation valid
- in_rdy  out  1  input activation ready
- out_rdy  in  1  downstream ready for the output vector
- out_v  out  1  output vector valid
- dp_en  out  1  datapath pipeline enable (=~stall)
- do_mvau_stream  out  1  a compute beat occurs this cycle
- ib_wen  out  1  input buffer write enable
- ib_ren  out  1  input buffer read enable
- acc_clr  out  1  accumulator loads instead of adding (first beat of an SF sweep)
- sf_last  out  1  sf_cnt==SF-1
- sf_cnt  out  SF_T  input buffer address
- nf_cnt  out  NF_T  current output-vector index

Behaviour:
- Reset: asynchronous on rst_n low. state=FILL, sf_cnt=0, nf_cnt=0, lat_sr=0. Therefore out_v=0 and all beat-qualified outputs are 0. in_rdy is 0 while rst_n is low.
- stall = out_v & ~out_rdy. dp_en = ~stall.
- States:
  - FILL: input buffer being written from the stream.
  - REUSE: input buffer read back for nf_cnt>0.
- in_rdy = (state==FILL) & ~stall.
- Beat definition:
  - FILL: beat = in_v & in_rdy.
  - REUSE: beat = ~stall.
  - do_mvau_stream = beat.
- ib_wen = beat & FILL. ib_ren = beat & REUSE. Both are combinational and never high together.
- acc_clr = beat & (sf_cnt==0). sf_last is combinational from sf_cnt.
- sf_cnt: increments on a beat and wraps to 0 on a beat with sf_last. It holds when there is no beat. For SF=1 it stays 0 and sf_last stays 1.
- nf_cnt: increments on beat & sf_last. It wraps to 0 on beat & sf_last when nf_cnt==NF-1. For NF=1 it stays 0.
- Transitions:
  - FILL→REUSE on beat & sf_last when NF>1.
  - REUSE→FILL on beat & sf_last & nf_cnt==NF-1.
  - NF=1: the block never leaves FILL.
- Latency pipeline: lat_sr[ACC_LAT-1:0] shifts only when dp_en=1.
  - lat_sr[0] <= beat & sf_last; lat_sr[i] <= lat_sr[i-1].
  - out_v = lat_sr[ACC_LAT-1].
  - With no stall, out_v is high exactly ACC_LAT cycles after the sf_last beat.
- Output handshake: an output transfer occurs when out_v & out_rdy. While stalled, every register holds: counters, state and lat_sr. No beat occurs. out_v stays high until accepted. No result is ever dropped or duplicated.
- Stall during FILL: in_rdy is low, so in_v is held off by upstream.
- Simultaneous events:
  - An output transfer and a new sf_last beat may occur in the same cycle (no stall, both advance).
  - An input gap in FILL simply holds the counters.
- Throughput: with out_rdy=1 and continuous in_v, there is one beat per cycle and no bubbles between NF sweeps or between input vectors.
- Reset mid-operation: everything returns to the reset state immediately. The next accepted input writes address 0. Partially computed outputs are discarded.

Test Plan:
- NF=4, SF=8, ACC_LAT=2, out_rdy=1, in_v=1 continuous → 8 input beats with ib_wen, addresses 0..7.
  - in_rdy then low for 24 cycles with ib_ren, addresses cycling 0..7 three times.
  - out_v pulses once every 8 cycles, 4 times total; the first pulse comes 2 cycles after the sf_cnt=7 beat.
  - The second input vector is accepted in the cycle after the last REUSE beat.
- FILL with in_v toggling 1,0,1,0 → sf_cnt advances only on accepted cycles. acc_clr occurs only on the first accepted beat. The out_v count is unchanged.
- out_rdy held 0 for 5 cycles while out_v=1 → dp_en=0, in_rdy=0, sf_cnt/nf_cnt/state frozen, out_v stays 1. After out_rdy=1, counting resumes from the frozen value and exactly NF outputs total are produced.
- NF=1, SF=4 → in_rdy stays 1 (except while stalled), ib_ren never asserted, out_v once per 4 accepted beats.
- SF=1, NF=3 → sf_last constant 1, acc_clr on every beat. One FILL beat is followed by 2 REUSE beats, giving 3 out_v pulses.
- rst_n asserted asynchronously mid-REUSE (nf_cnt=2, sf_cnt=5) → all outputs 0 without a clock edge. After release, in_rdy=1 and the first accepted beat has sf_cnt=0 with ib_wen=1.
